// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: input FIFO, integer baud divider, LSB-first framed serialiser
// Optional line-break control is compiled in with UART_TX_BREAK_EN.
module uart_tx_engine #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_CLK_DIV         = 16,
  parameter int P_FIFO_DEPTH      = 4
) (
  input  logic                          i_u_clk,
  input  logic                          i_u_rst,
  input  logic [P_UART_DATA_WIDTH-1:0]  i_uart_tx_data,
  input  logic                          i_uart_tx_valid,
  output logic                          o_uart_tx_ready,
  input  logic [1:0]                    i_cfg_parity,
  input  logic                          i_cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_tx_break,
`endif
  output logic                          o_uart_tx,
  output logic                          o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0] o_fifo_level
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = $clog2(P_CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(P_CLK_DIV - 1);
  localparam logic [3:0]    BIT_MAX  = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    BREAK,
    MARK,
`endif
    STOP
  } state_t;

  logic [P_UART_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [AW:0]                  level;
  logic [AW:0]                  level_nxt;
  logic                         push;
  logic                         pop;

  state_t                       state;
  logic [CW-1:0]                baud_cnt;
  logic [3:0]                   bit_cnt;
  logic                         stop_cnt;
  logic [P_UART_DATA_WIDTH-1:0] shift;
  logic                         par_acc;
  logic [1:0]                   par_mode;
  logic                         stop2;
  logic                         tick;
  logic                         last_stop;
  logic                         par_en;
  logic                         brk;
  logic                         line;

  // Ready is a register, so a write while full is dropped even if a pop happens on that edge.
  assign push         = i_uart_tx_valid & o_uart_tx_ready;
  assign o_fifo_level = level;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + (AW+1)'(1);
    else if (pop && !push)
      level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      o_uart_tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level           <= level_nxt;
      o_uart_tx_ready <= (level_nxt != LVL_FULL);
    end
  end

  always_ff @(posedge i_u_clk) begin
    if (push) mem[wr_ptr] <= i_uart_tx_data;
  end

  assign tick      = (baud_cnt == CNT_MAX);
  assign last_stop = (stop_cnt == stop2);
  assign par_en    = (par_mode == 2'd1) || (par_mode == 2'd2);
`ifdef UART_TX_BREAK_EN
  assign brk       = i_tx_break;
`else
  assign brk       = 1'b0;
`endif

  // A word is taken only at a frame boundary: from idle, or on the last stop-bit tick.
  always_comb begin
    pop = 1'b0;
    if (level != '0 && !brk) begin
      case (state)
        IDLE:    pop = 1'b1;
        STOP:    pop = tick & last_stop;
`ifdef UART_TX_BREAK_EN
        MARK:    pop = tick;
`endif
        default: pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = par_acc ^ (par_mode == 2'd1);
`ifdef UART_TX_BREAK_EN
      BREAK:   line = 1'b0;
`endif
      default: line = 1'b1;
    endcase
  end

  // Line and busy follow the state one edge late, so every bit still lasts exactly P_CLK_DIV cycles.
  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      par_acc   <= 1'b0;
      par_mode  <= '0;
      stop2     <= 1'b0;
      o_uart_tx <= 1'b1;
      o_tx_busy <= 1'b0;
    end else begin
      o_uart_tx <= line;
      o_tx_busy <= (state != IDLE);
      baud_cnt  <= tick ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk) state <= BREAK;
`endif
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            par_acc <= par_acc ^ shift[0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_MAX) begin
              state    <= par_en ? PARITY : STOP;
              stop_cnt <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (!last_stop)
              stop_cnt <= 1'b1;
`ifdef UART_TX_BREAK_EN
            else if (brk)
              state <= BREAK;
`endif
            else
              state <= IDLE;
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!brk) begin
            state    <= MARK;
            baud_cnt <= '0;
          end
        end
        MARK: begin
          if (tick) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
      if (pop) begin
        shift    <= mem[rd_ptr];
        par_mode <= i_cfg_parity;
        stop2    <= i_cfg_stop2;
        baud_cnt <= '0;
        state    <= START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine against a frame-level reference model
module tb_uart_tx_engine;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int D   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic [1:0]   par;
  logic         stop2;
  logic         tx;
  logic         busy;
  logic [$clog2(D):0] level;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_engine #(.P_UART_DATA_WIDTH(W), .P_CLK_DIV(DIV), .P_FIFO_DEPTH(D)) dut (
    .i_u_clk        (clk),
    .i_u_rst        (rst),
    .i_uart_tx_data (data),
    .i_uart_tx_valid(valid),
    .o_uart_tx_ready(ready),
    .i_cfg_parity   (par),
    .i_cfg_stop2    (stop2),
`ifdef UART_TX_BREAK_EN
    .i_tx_break     (1'b0),
`endif
    .o_uart_tx      (tx),
    .o_tx_busy      (busy),
    .o_fifo_level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus a queue of per-cycle line values for accepted frames.
  logic [W-1:0] mq[$];
  bit           lq[$];
  int           rem = 0;
  bit           m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_started = 1'b0;
  int           m_level = 0;

  always @(posedge clk) begin
    bit push, popn, pb;
    logic [W-1:0] w;
    m_started = 1'b1;
    if (rst) begin
      mq.delete();
      lq.delete();
      rem    = 0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      push = valid && (mq.size() != D);
      popn = (rem <= 1) && (mq.size() != 0);
      if (lq.size() > 0) begin
        m_tx   = lq.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      if (popn) begin
        w = mq.pop_front();
        rem = 0;
        for (int c = 0; c < DIV; c++) lq.push_back(1'b0);
        rem += DIV;
        for (int b = 0; b < W; b++) begin
          for (int c = 0; c < DIV; c++) lq.push_back(w[b]);
          rem += DIV;
        end
        if (par == 2'd1 || par == 2'd2) begin
          pb = (par == 2'd2) ? (^w) : ~(^w);
          for (int c = 0; c < DIV; c++) lq.push_back(pb);
          rem += DIV;
        end
        for (int s = 0; s < (stop2 ? 2 : 1); s++) begin
          for (int c = 0; c < DIV; c++) lq.push_back(1'b1);
          rem += DIV;
        end
      end else if (rem > 0) begin
        rem--;
      end
      if (push) mq.push_back(data);
    end
    m_level = mq.size();
    m_ready = (mq.size() != D);
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_tx",    int'(tx),    int'(m_tx));
      check("model_busy",  int'(busy),  int'(m_busy));
      check("model_ready", int'(ready), int'(m_ready));
      check("model_level", int'(level), m_level);
    end
  end

  int busy_run = 0;
  int last_busy_len = 0;
  always @(negedge clk) begin
    if (busy) busy_run++;
    else begin
      if (busy_run > 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic send(input logic [W-1:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || level != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", int'(busy || level != 0), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic grab(input int nbits, output logic [15:0] bits);
    int t = 0;
    bits = '0;
    while (tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("frame_start_timeout", int'(tx), 0);
    @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      bits[b] = tx;
      if (b < nbits - 1) repeat (DIV) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0]  seq55;
    logic [15:0] fb;
    int lows;
    seq55 = 10'b1010101010;
    rst = 1'b1; valid = 1'b0; data = '0; par = 2'd0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55, 8N1: start bit two edges after the handshake, 40 busy cycles
    send(8'h55);
    check("t55_level_after_write", int'(level), 1);
    @(negedge clk);
    check("t55_line_before_start", int'(tx), 1);
    check("t55_busy_before_start", int'(busy), 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("t55_line", int'(tx), int'(seq55[k/DIV]));
      check("t55_busy", int'(busy), 1);
    end
    @(negedge clk);
    check("t55_line_end", int'(tx), 1);
    check("t55_busy_end", int'(busy), 0);
    @(negedge clk);
    check("t55_busy_len", last_busy_len, 40);

    // parity: 0x07 has three ones
    par = 2'd2;
    send(8'h07);
    grab(11, fb);
    check("even_data", int'(fb[8:1]), 7);
    check("even_parity", int'(fb[9]), 1);
    wait_idle();
    check("even_len", last_busy_len, 44);
    par = 2'd1;
    send(8'h07);
    grab(11, fb);
    check("odd_parity", int'(fb[9]), 0);
    wait_idle();
    par = 2'd2; stop2 = 1'b1;
    send(8'h07);
    grab(12, fb);
    check("stop2_bit1", int'(fb[10]), 1);
    check("stop2_bit2", int'(fb[11]), 1);
    wait_idle();
    check("stop2_len", last_busy_len, 48);
    par = 2'd0; stop2 = 1'b0;

    // FIFO fill: six consecutive valid edges, five accepted, frames back-to-back
    for (int i = 0; i < 6; i++) begin
      check("fill_ready", int'(ready), (i < 5) ? 1 : 0);
      valid = 1'b1;
      data  = W'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    check("fill_level", int'(level), 4);
    wait_idle();
    check("fill_b2b_len", last_busy_len, 200);

    // configuration change during DATA only affects the next frame
    send(8'hA3);
    send(8'h3C);
    repeat (10) @(negedge clk);
    par = 2'd2;
    wait_idle();
    check("cfg_change_len", last_busy_len, 84);
    par = 2'd0;

    // reset mid-DATA with a word still queued
    send(8'h00);
    send(8'h0F);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("post_rst_quiet", lows, 0);

    // randomized traffic with occasional configuration changes
    for (int k = 0; k < 1500; k++) begin
      valid = ($urandom_range(0, 9) == 0);
      data  = W'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        par   = 2'($urandom_range(0, 3));
        stop2 = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
